logic_unit_pipe: RTL and testbench

//   Parametrised, registered bitwise logic unit for the extended DLX datapath. Successor to the fixed
//   32-bit single-function logic gates: one block covers the full op set at any width.

---
 rtl/logic_unit_pipe.sv | 143 ++++++++++++++
 tb/tb_logic_unit_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake and a multi-beat
// accumulate (chain) mode that folds successive B operands into one result.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no chain open; the next beat is a single op or starts a new chain
// ACCUM | chain open; acc_q holds the partial result, cnt_q the beats merged
module logic_unit_pipe #(
  parameter  int WIDTH   = 32,
  parameter  int ACC_MAX = 16,
  localparam int CNT_W   = $clog2(ACC_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_MAX);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [WIDTH-1:0]   op_x;
  logic [WIDTH-1:0]   f_val;
  logic [CNT_W-1:0]   cnt_inc;
  logic               chain_close;

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x | y);
      3'b100:  r = x & ~y;
      3'b101:  r = x | ~y;
      3'b110:  r = y;
      default: r = ~(x & y);
    endcase
    return r;
  endfunction

  // Ready only when the result slot is free or being drained this cycle, so
  // no beat (closing or not) is ever taken while a result sits unconsumed.
  assign in_ready    = !rst && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;

  assign op_x        = (state_q == ACCUM) ? acc_q : a;
  assign f_val       = logic_op(op, op_x, b);
  assign cnt_inc     = cnt_q + CNT_ONE;
  assign chain_close = acc_last || !acc_en || (cnt_inc == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q && !out_ready;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (acc_en && !acc_last) begin
            state_d = ACCUM;
            acc_d   = f_val;
            cnt_d   = CNT_ONE;
          end else begin
            res_d       = f_val;
            rcnt_d      = CNT_ONE;
            out_valid_d = 1'b1;
          end
        end
        ACCUM: begin
          if (chain_close) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            res_d       = f_val;
            rcnt_d      = cnt_inc;
            out_valid_d = 1'b1;
          end else begin
            acc_d = f_val;
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_count  = rcnt_q;
  assign out_zero   = (res_q == '0);

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a default instance (ACC_MAX=16) and an
// ACC_MAX=4 instance share stimulus; expected results are queued per instance.
module tb_logic_unit_pipe;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    int           cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, acc_en, acc_last, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;

  logic         in_ready, out_valid, out_zero;
  logic [W-1:0] out_result;
  logic [4:0]   out_count;

  logic         s_in_ready, s_out_valid, s_out_zero;
  logic [W-1:0] s_out_result;
  logic [2:0]   s_out_count;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .ACC_MAX(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_en(acc_en), .acc_last(acc_last), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_count(out_count)
  );

  logic_unit_pipe #(.WIDTH(W), .ACC_MAX(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
    .acc_en(acc_en), .acc_last(acc_last), .a(a), .b(b), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_result(s_out_result), .out_zero(s_out_zero),
    .out_count(s_out_count)
  );

  // Presents one beat from posedge+1 and leaves the bench at the next posedge+1.
  task automatic drive(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic en, input logic last);
    in_valid = 1'b1; op = o; a = av; b = bv; acc_en = en; acc_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    acc_en = 1'b0; acc_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== '0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    checks++; if (out_count !== 5'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (out_zero !== 1'b1) begin failures++; $display("FAIL reset_out_zero got=%b exp=1", out_zero); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    exp_t e;
    q0.push_back('{res: 32'hF0F0_0F0F, cnt: 1});
    drive(3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++;
    if (q0.size() == 0) begin failures++; $display("FAIL single_sb got=empty exp=entry"); end
    else begin
      e = q0.pop_front();
      if (out_result !== e.res || out_count !== 5'(e.cnt) || out_zero !== (e.res == '0)) begin
        failures++;
        $display("FAIL single_result got=%h/%0d/%b exp=%h/%0d/%b", out_result, out_count, out_zero, e.res, e.cnt, e.res == '0);
      end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    checks++; if (out_result !== 32'hF0F0_0F0F) begin failures++; $display("FAIL single_hold got=%h exp=f0f00f0f", out_result); end
  endtask

  task automatic test_op_sweep();
    logic [W-1:0] tbl [8];
    exp_t e;
    tbl = '{32'h8888_8888, 32'hEEEE_EEEE, 32'h6666_6666, 32'h1111_1111,
            32'h2222_2222, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'h7777_7777};
    for (int i = 0; i < 8; i++) begin
      q0.push_back('{res: tbl[i], cnt: 1});
      drive(3'(i), 32'hAAAA_AAAA, 32'hCCCC_CCCC, 1'b0, 1'b0);
      checks++;
      if (q0.size() == 0 || out_valid !== 1'b1) begin
        failures++; $display("FAIL sweep_valid op=%0d got=%b exp=1", i, out_valid);
        q0.delete();
      end else begin
        e = q0.pop_front();
        if (out_result !== e.res || out_count !== 5'(e.cnt)) begin
          failures++; $display("FAIL sweep_op%0d got=%h/%0d exp=%h/%0d", i, out_result, out_count, e.res, e.cnt);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_chain();
    exp_t e;
    drive(3'b001, 32'h1, 32'h2, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL chain_beat1_valid got=%b exp=0", out_valid); end
    drive(3'b001, 32'hFFFF_FFFF, 32'h4, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL chain_beat2_valid got=%b exp=0", out_valid); end
    q0.push_back('{res: 32'h0000_000F, cnt: 3});
    drive(3'b001, 32'hFFFF_FFFF, 32'h8, 1'b1, 1'b1);
    checks++;
    if (q0.size() == 0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL chain_last_valid got=%b exp=1", out_valid); q0.delete();
    end else begin
      e = q0.pop_front();
      if (out_result !== e.res || out_count !== 5'(e.cnt)) begin
        failures++; $display("FAIL chain_last got=%h/%0d exp=%h/%0d", out_result, out_count, e.res, e.cnt);
      end
    end
    // chain closed by a non-chain beat, with op changing mid-chain
    drive(3'b000, 32'h0000_00FF, 32'h0000_000F, 1'b1, 1'b0);
    q0.push_back('{res: 32'h0000_000C, cnt: 2});
    drive(3'b010, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0);
    checks++;
    if (q0.size() == 0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL chain_en0_valid got=%b exp=1", out_valid); q0.delete();
    end else begin
      e = q0.pop_front();
      if (out_result !== e.res || out_count !== 5'(e.cnt)) begin
        failures++; $display("FAIL chain_en0 got=%h/%0d exp=%h/%0d", out_result, out_count, e.res, e.cnt);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_acc_max();
    logic [W-1:0] bv [7];
    logic [W-1:0] av [7];
    exp_t e;
    bv = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h200, 32'h400, 32'h0};
    av = '{32'h1, 32'hDEAD, 32'hBEEF, 32'h5555, 32'h100, 32'h7777, 32'h9999};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) q1.push_back('{res: 32'h0000_001F, cnt: 4});
      if (i == 6) begin
        q1.push_back('{res: 32'h0000_0700, cnt: 3});
        q0.push_back('{res: 32'h0000_061F, cnt: 7});
      end
      drive(3'b010, av[i], bv[i], (i != 6), 1'b0);
      if (i == 3 || i == 6) begin
        checks++;
        if (q1.size() == 0 || s_out_valid !== 1'b1) begin
          failures++; $display("FAIL accmax_emit beat=%0d got=%b exp=1", i + 1, s_out_valid); q1.delete();
        end else begin
          e = q1.pop_front();
          if (s_out_result !== e.res || s_out_count !== 3'(e.cnt)) begin
            failures++; $display("FAIL accmax_result beat=%0d got=%h/%0d exp=%h/%0d", i + 1, s_out_result, s_out_count, e.res, e.cnt);
          end
        end
      end else begin
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL accmax_quiet beat=%0d got=%b exp=0", i + 1, s_out_valid); end
      end
    end
    checks++;
    if (q0.size() == 0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL accmax_wide_valid got=%b exp=1", out_valid); q0.delete();
    end else begin
      e = q0.pop_front();
      if (out_result !== e.res || out_count !== 5'(e.cnt)) begin
        failures++; $display("FAIL accmax_wide got=%h/%0d exp=%h/%0d", out_result, out_count, e.res, e.cnt);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b0;
    q0.push_back('{res: 32'hFF00_0000, cnt: 1});
    drive(3'b000, 32'hFFFF_0000, 32'hFF00_FF00, 1'b0, 1'b0);
    in_valid = 1'b1; op = 3'b010; a = 32'h0; b = 32'h1234_5678; acc_en = 1'b0; acc_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'hFF00_0000) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=rdy%b/v%b/%h exp=rdy0/v1/ff000000", k, in_ready, out_valid, out_result);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    checks++;
    if (q0.size() == 0) begin failures++; $display("FAIL bp_sb got=empty exp=entry"); end
    else begin
      e = q0.pop_front();
      if (out_result !== e.res || out_count !== 5'(e.cnt)) begin
        failures++; $display("FAIL bp_first got=%h/%0d exp=%h/%0d", out_result, out_count, e.res, e.cnt);
      end
    end
    q0.push_back('{res: 32'h1234_5678, cnt: 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (q0.size() == 0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_swap_valid got=%b exp=1", out_valid); q0.delete();
    end else begin
      e = q0.pop_front();
      if (out_result !== e.res || out_count !== 5'(e.cnt)) begin
        failures++; $display("FAIL bp_swap got=%h/%0d exp=%h/%0d", out_result, out_count, e.res, e.cnt);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // result pending under backpressure, then reset
    out_ready = 1'b0;
    drive(3'b010, 32'h1, 32'h3, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h2) begin failures++; $display("FAIL rst_pending_setup got=%b/%h exp=1/2", out_valid, out_result); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_count !== 5'd0 || out_zero !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_pending got=v%b/%h/%0d/z%b/rdy%b exp=v0/0/0/z1/rdy0", out_valid, out_result, out_count, out_zero, in_ready);
    end
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    // open chain of two beats, then reset
    drive(3'b001, 32'h1, 32'h2, 1'b1, 1'b0);
    drive(3'b001, 32'h0, 32'h4, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_count !== 5'd0 || out_zero !== 1'b1) begin
      failures++; $display("FAIL rst_chain got=v%b/%h/%0d/z%b exp=v0/0/0/z1", out_valid, out_result, out_count, out_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    q0.push_back('{res: 32'h0, cnt: 1});
    drive(3'b000, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (q0.size() == 0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rst_after_valid got=%b exp=1", out_valid); q0.delete();
    end else begin
      e = q0.pop_front();
      if (out_result !== e.res || out_count !== 5'(e.cnt) || out_zero !== 1'b1) begin
        failures++; $display("FAIL rst_after got=%h/%0d/z%b exp=%h/%0d/z1", out_result, out_count, out_zero, e.res, e.cnt);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_op_sweep();
    test_chain();
    test_acc_max();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
